hazard_unit: RTL

Pipeline hazard controller for the 5-stage core, and the producer of the register tags the forwarding logic consumes. It tracks destination-register records of in-flight instructions through EX, MEM and WB, and publishes `ex_rs`, `ex_rt`, `mem_rd` and `wb_rd` to the forward unit. Each cycle it resolves load-use, data-cache wait, instruction-fetch miss, taken-branch and halt conditions into per-latch enable/flush controls.

---
 rtl/cpu_types_pkg.sv | 45 ++++
 rtl/hazard_unit_if.sv | 23 ++
 rtl/hz_stage_reg.sv | 34 +++
 rtl/hazard_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the core's hazard tracking: register tags, hazard
// actions and the per-stage destination record.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        WAIT   = 2'd2,
        HALTED = 2'd3
    } hz_state_t;

    typedef struct packed {
        regbits_t rs;
        regbits_t rt;
        regbits_t rd;
        logic     wen;
        logic     memrd;
        logic     memwr;
        logic     halt;
    } hz_rec_t;

    // Register 0 is hardwired, so a write to it must never look like a producer.
    function automatic hz_rec_t make_rec(
        input regbits_t rs,
        input regbits_t rt,
        input regbits_t rd,
        input logic     wen,
        input logic     memrd,
        input logic     memwr,
        input logic     halt
    );
        hz_rec_t r;
        r.rs    = rs;
        r.rt    = rt;
        r.rd    = rd;
        r.wen   = wen & (rd != '0);
        r.memrd = memrd;
        r.memwr = memwr;
        r.halt  = halt;
        return r;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of the hazard unit's decode inputs, tags and pipeline controls.
interface hazard_unit_if #(parameter int unsigned CNT_W = 16);
    import cpu_types_pkg::*;

    regbits_t         id_rs, id_rt, id_rd;
    logic             id_regwrite, id_memread, id_memwrite, id_halt;
    logic             ihit, dhit, branch_taken;
    regbits_t         ex_rs, ex_rt, mem_rd, wb_rd;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_count;

    modport hzu (
        input  id_rs, id_rt, id_rd, id_regwrite, id_memread, id_memwrite, id_halt,
        input  ihit, dhit, branch_taken,
        output ex_rs, ex_rt, mem_rd, wb_rd,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush,
        output hz_state, stall_count
    );

endinterface

// File: rtl/hz_stage_reg.sv
// One pipeline-stage record register; flush loads a bubble and wins over enable.
module hz_stage_reg
    import cpu_types_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    en_i,
    input  logic    flush_i,
    input  hz_rec_t d_i,
    output hz_rec_t q_o
);

    hz_rec_t rec_q, rec_d;

    always_comb begin
        rec_d = rec_q;
        if (flush_i) begin
            rec_d = '0;
        end else if (en_i) begin
            rec_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign q_o = rec_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: tracks EX/MEM/WB destination records, publishes
// forwarding tags and resolves stalls, flushes and halt into latch controls.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
)
(
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_halt,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             branch_taken,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       mem_rd,
    output logic [4:0]       wb_rd,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_count
);

    hz_rec_t          id_rec, ex_q, mem_q, wb_q;
    hz_state_t        state_q, state_d, act;
    logic             mem_busy, load_use;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_wb;

    always_comb id_rec = make_rec(id_rs, id_rt, id_rd, id_regwrite,
                                  id_memread, id_memwrite, id_halt);

    hz_stage_reg u_ex (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (idex_en),
        .flush_i (idex_flush),
        .d_i     (id_rec),
        .q_o     (ex_q)
    );

    hz_stage_reg u_mem (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (exmem_en),
        .flush_i (exmem_flush),
        .d_i     (ex_q),
        .q_o     (mem_q)
    );

    hz_stage_reg u_wb (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (memwb_en),
        .flush_i (1'b0),
        .d_i     (mem_q),
        .q_o     (wb_q)
    );

    assign mem_busy = (mem_q.memrd | mem_q.memwr) & ~dhit;
    assign load_use = ex_q.memrd & ex_q.wen & (ex_q.rd != '0) &
                      ((ex_q.rd == id_rs) | (ex_q.rd == id_rt));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority chain: halted, dcache wait, taken branch, load-use, icache miss.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        act         = RUN;
        state_d     = (state_q == HALTED || wb_q.halt) ? HALTED : RUN;

        if (state_q == HALTED || mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            act      = (state_q == HALTED) ? HALTED : WAIT;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            act         = STALL;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            act        = STALL;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            act        = STALL;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!pc_en && act != HALTED && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hz_state    = act;
    assign stall_count = cnt_q;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign mem_rd      = mem_q.wen ? mem_q.rd : '0;
    assign wb_rd       = wb_q.wen ? wb_q.rd : '0;
    assign unused_wb   = ^{wb_q.rs, wb_q.rt, wb_q.memrd, wb_q.memwr};

endmodule
